// File: rtl/greg_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
//   W_OPR_DEF    default operand width
//   REG_N_DEF    default register count
//   PEND_MAX_DEF default limit on outstanding reservations per register
//   CNT_W_DEF    width of a pending counter able to hold 0..PEND_MAX_DEF
//   clog2()      ceiling log2, clog2(1) = 0
package greg_pkg;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int W_OPR_DEF    = 32;
  localparam int REG_N_DEF    = 16;
  localparam int PEND_MAX_DEF = 3;
  localparam int CNT_W_DEF    = clog2(PEND_MAX_DEF + 1);

endpackage

// File: rtl/greg_entry.sv
// One register of the scoreboarded register file: operand data plus a
// pending-write counter.
//   clk, rst  clock, synchronous active-high reset
//   inc       accepted reservation for this register this cycle
//   hits      number of write-back ports targeting this register this cycle
//   wr_data   data of the highest-index write-back port hitting this register
//   data, cnt current stored operand and pending count
//   uflow     this cycle's write-backs exceed cnt + inc (counter will clamp)
module greg_entry
  import greg_pkg::*;
#(
  parameter int W_OPR = W_OPR_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int HIT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [HIT_W-1:0] hits,
  input  logic [W_OPR-1:0] wr_data,
  output logic [W_OPR-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             uflow
);

  logic [31:0]      avail;
  logic [31:0]      take;
  logic [CNT_W-1:0] cnt_d;

  // Reservation and write-backs net out in one edge; a write-back with no
  // outstanding reservation pins the counter at zero.
  always_comb begin
    avail = 32'(cnt) + 32'(inc);
    take  = 32'(hits);
    uflow = (take > avail);
    cnt_d = uflow ? '0 : CNT_W'(avail - take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      cnt <= cnt_d;
      if (hits != '0) data <= wr_data;
    end
  end

endmodule

// File: rtl/g_regfile_sb.sv
// Register file with a per-register pending-write scoreboard.
// Reads are combinational and report busy while writes are outstanding;
// reservations count up, write-backs count down and store data.
// Optional macro GREG_BYPASS_EN forwards same-cycle write-back data and
// clears busy on reads in the write-back cycle.
//   clk, rst     clock, synchronous active-high reset
//   w_reserve_i  reservation request for register rsv_r_i
//   rsv_stall_o  reservation refused (register already at PEND_MAX)
//   rd_r_i       N_RD read register numbers, port k in slice k
//   rd_data_o    N_RD read operands
//   rd_busy_o    per read port: operand still pending
//   wb_i         per write-back port valid
//   wb_r_i       N_WB write-back register numbers
//   wb_data_i    N_WB write-back operands
//   wb_err_o     sticky: some write-back hit a register with nothing pending
module g_regfile_sb
  import greg_pkg::*;
#(
  parameter int W_OPR    = W_OPR_DEF,
  parameter int REG_N    = REG_N_DEF,
  parameter int N_RD     = 2,
  parameter int N_WB     = 2,
  parameter int PEND_MAX = PEND_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_reserve_i,
  input  logic [clog2(REG_N)-1:0]     rsv_r_i,
  output logic                        rsv_stall_o,
  input  logic [N_RD*clog2(REG_N)-1:0] rd_r_i,
  output logic [N_RD*W_OPR-1:0]       rd_data_o,
  output logic [N_RD-1:0]             rd_busy_o,
  input  logic [N_WB-1:0]             wb_i,
  input  logic [N_WB*clog2(REG_N)-1:0] wb_r_i,
  input  logic [N_WB*W_OPR-1:0]       wb_data_i,
  output logic                        wb_err_o
);

  localparam int AW    = clog2(REG_N);
  localparam int CNT_W = clog2(PEND_MAX + 1);
  localparam int HIT_W = clog2(N_WB + 1);

  logic [W_OPR-1:0] data_a [REG_N];
  logic [CNT_W-1:0] cnt_a  [REG_N];
  logic [HIT_W-1:0] hits_a [REG_N];
  logic [W_OPR-1:0] wr_a   [REG_N];
  logic [REG_N-1:0] inc_v;
  logic [REG_N-1:0] uflow_v;
  logic [AW-1:0]    rsel;

  assign rsv_stall_o = w_reserve_i & (cnt_a[rsv_r_i] == CNT_W'(PEND_MAX));

  // Per-register decode; ascending port scan leaves the highest-index
  // matching write-back data in wr_a.
  always_comb begin
    for (int i = 0; i < REG_N; i++) begin
      inc_v[i]  = w_reserve_i & ~rsv_stall_o & (rsv_r_i == AW'(i));
      hits_a[i] = '0;
      wr_a[i]   = '0;
      for (int j = 0; j < N_WB; j++) begin
        if (wb_i[j] && (wb_r_i[j*AW +: AW] == AW'(i))) begin
          hits_a[i] = hits_a[i] + HIT_W'(1);
          wr_a[i]   = wb_data_i[j*W_OPR +: W_OPR];
        end
      end
    end
  end

  for (genvar g = 0; g < REG_N; g++) begin : g_entry
    greg_entry #(
      .W_OPR (W_OPR),
      .CNT_W (CNT_W),
      .HIT_W (HIT_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_v[g]),
      .hits    (hits_a[g]),
      .wr_data (wr_a[g]),
      .data    (data_a[g]),
      .cnt     (cnt_a[g]),
      .uflow   (uflow_v[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)            wb_err_o <= 1'b0;
    else if (|uflow_v)  wb_err_o <= 1'b1;
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rsel      = '0;
    for (int k = 0; k < N_RD; k++) begin
      rsel = rd_r_i[k*AW +: AW];
`ifdef GREG_BYPASS_EN
      // Busy only if something stays pending after this cycle's write-backs.
      rd_busy_o[k] = (32'(cnt_a[rsel]) > 32'(hits_a[rsel]));
      rd_data_o[k*W_OPR +: W_OPR] = (hits_a[rsel] != '0) ? wr_a[rsel] : data_a[rsel];
`else
      rd_busy_o[k] = (cnt_a[rsel] != '0);
      rd_data_o[k*W_OPR +: W_OPR] = data_a[rsel];
`endif
    end
  end

endmodule

// File: tb/tb_g_regfile_sb.sv
module tb_g_regfile_sb;

  localparam int W   = 32;
  localparam int N   = 16;
  localparam int AW  = 4;
  localparam int NRD = 2;
  localparam int NWB = 2;
  localparam int PM  = 3;

  logic              clk;
  logic              rst;
  logic              w_reserve_i;
  logic [AW-1:0]     rsv_r_i;
  logic              rsv_stall_o;
  logic [NRD*AW-1:0] rd_r_i;
  logic [NRD*W-1:0]  rd_data_o;
  logic [NRD-1:0]    rd_busy_o;
  logic [NWB-1:0]    wb_i;
  logic [NWB*AW-1:0] wb_r_i;
  logic [NWB*W-1:0]  wb_data_i;
  logic              wb_err_o;

  g_regfile_sb #(
    .W_OPR(W), .REG_N(N), .N_RD(NRD), .N_WB(NWB), .PEND_MAX(PM)
  ) dut (
    .clk(clk), .rst(rst),
    .w_reserve_i(w_reserve_i), .rsv_r_i(rsv_r_i), .rsv_stall_o(rsv_stall_o),
    .rd_r_i(rd_r_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
    .wb_err_o(wb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef GREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference model: register contents, pending counts, sticky error.
  logic [W-1:0] m_data [N];
  int           m_cnt  [N];
  bit           m_err;

  int checks;
  int failures;

  function automatic int hit_cnt(input int r);
    int h = 0;
    for (int j = 0; j < NWB; j++)
      if (wb_i[j] && int'(wb_r_i[j*AW +: AW]) == r) h++;
    return h;
  endfunction

  function automatic logic [W-1:0] last_wb(input int r);
    logic [W-1:0] d = '0;
    for (int j = 0; j < NWB; j++)
      if (wb_i[j] && int'(wb_r_i[j*AW +: AW]) == r) d = wb_data_i[j*W +: W];
    return d;
  endfunction

  function automatic logic exp_stall();
    return w_reserve_i && (m_cnt[int'(rsv_r_i)] == PM);
  endfunction

  function automatic logic exp_busy(input int r);
    if (BYP) return (m_cnt[r] - hit_cnt(r)) > 0;
    return m_cnt[r] != 0;
  endfunction

  function automatic logic [W-1:0] exp_data(input int r);
    if (BYP && hit_cnt(r) > 0) return last_wb(r);
    return m_data[r];
  endfunction

  // Advance the model with the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit st;
    int nc;
    st = exp_stall();
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        m_data[r] = '0;
        m_cnt[r]  = 0;
      end
      m_err = 1'b0;
    end else begin
      for (int r = 0; r < N; r++) begin
        nc = m_cnt[r] + ((w_reserve_i && !st && int'(rsv_r_i) == r) ? 1 : 0) - hit_cnt(r);
        if (nc < 0) begin
          nc = 0;
          m_err = 1'b1;
        end
        if (hit_cnt(r) > 0) m_data[r] = last_wb(r);
        m_cnt[r] = nc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_reserve_i = 1'b0;
    wb_i        = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_reserve_i = 1'b1; rsv_r_i = 4'd5;
    wb_i = 2'b01; wb_r_i[0 +: AW] = 4'd5; wb_data_i[0 +: W] = 32'hAAAA_5555;
    tick();
    rst = 1'b0;
    idle();
    rd_r_i[0 +: AW] = 4'd5;
    w_reserve_i = 1'b1; rsv_r_i = 4'd5;
    #1;
    checks++;
    if (rd_data_o[0 +: W] !== 32'h0) begin
      failures++; $display("FAIL reset_data got %h exp 0", rd_data_o[0 +: W]);
    end
    checks++;
    if (rd_busy_o[0] !== 1'b0) begin
      failures++; $display("FAIL reset_busy got %b exp 0", rd_busy_o[0]);
    end
    checks++;
    if (wb_err_o !== 1'b0) begin
      failures++; $display("FAIL reset_err got %b exp 0", wb_err_o);
    end
    checks++;
    if (rsv_stall_o !== 1'b0) begin
      failures++; $display("FAIL reset_stall got %b exp 0", rsv_stall_o);
    end
    idle();
    #1;
  endtask

  task automatic test_reserve_wb();
    rd_r_i[0 +: AW] = 4'd3;
    w_reserve_i = 1'b1; rsv_r_i = 4'd3;
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b0) begin
      failures++; $display("FAIL rsv_same_cycle_busy got %b exp 0", rd_busy_o[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b1) begin
      failures++; $display("FAIL rsv_busy_c1 got %b exp 1", rd_busy_o[0]);
    end
    tick();
    wb_i = 2'b01; wb_r_i[0 +: AW] = 4'd3; wb_data_i[0 +: W] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rd_busy_o[0] !== !BYP) begin
      failures++; $display("FAIL rsv_busy_wb_cycle got %b exp %b", rd_busy_o[0], !BYP);
    end
    checks++;
    if (rd_data_o[0 +: W] !== (BYP ? 32'hDEAD_BEEF : 32'h0)) begin
      failures++; $display("FAIL rsv_data_wb_cycle got %h", rd_data_o[0 +: W]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b0) begin
      failures++; $display("FAIL wb_busy_after got %b exp 0", rd_busy_o[0]);
    end
    checks++;
    if (rd_data_o[0 +: W] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wb_data_after got %h exp deadbeef", rd_data_o[0 +: W]);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d;
    rd_r_i[0 +: AW] = 4'd7;
    for (int i = 0; i < 4; i++) begin
      w_reserve_i = 1'b1; rsv_r_i = 4'd7;
      #1;
      checks++;
      if (rsv_stall_o !== (i == 3)) begin
        failures++; $display("FAIL stall_%0d got %b exp %b", i, rsv_stall_o, (i == 3));
      end
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      wb_i = 2'b10; wb_r_i[AW +: AW] = 4'd7; wb_data_i[W +: W] = d;
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy_o[0] !== (i < 2)) begin
        failures++; $display("FAIL stall_drain_%0d busy got %b exp %b", i, rd_busy_o[0], (i < 2));
      end
      checks++;
      if (rd_data_o[0 +: W] !== d) begin
        failures++; $display("FAIL stall_drain_%0d data got %h exp %h", i, rd_data_o[0 +: W], d);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] d;
    d = $urandom;
    rd_r_i[0 +: AW] = 4'd2;
    w_reserve_i = 1'b1; rsv_r_i = 4'd2;
    tick();
    wb_i = 2'b01; wb_r_i[0 +: AW] = 4'd2; wb_data_i[0 +: W] = d;
    #1;
    checks++;
    if (rsv_stall_o !== 1'b0) begin
      failures++; $display("FAIL same_stall got %b exp 0", rsv_stall_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b1) begin
      failures++; $display("FAIL same_busy got %b exp 1", rd_busy_o[0]);
    end
    checks++;
    if (rd_data_o[0 +: W] !== d) begin
      failures++; $display("FAIL same_data got %h exp %h", rd_data_o[0 +: W], d);
    end
    wb_i = 2'b01; wb_r_i[0 +: AW] = 4'd2;
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b0) begin
      failures++; $display("FAIL same_clear got %b exp 0", rd_busy_o[0]);
    end
  endtask

  task automatic test_multi_wb();
    rd_r_i[AW +: AW] = 4'd4;
    w_reserve_i = 1'b1; rsv_r_i = 4'd4;
    tick();
    tick();
    idle();
    wb_i = 2'b11;
    wb_r_i[0 +: AW] = 4'd4; wb_data_i[0 +: W] = 32'h11;
    wb_r_i[AW +: AW] = 4'd4; wb_data_i[W +: W] = 32'h22;
    tick();
    idle();
    #1;
    checks++;
    if (rd_data_o[W +: W] !== 32'h22) begin
      failures++; $display("FAIL multi_data got %h exp 22", rd_data_o[W +: W]);
    end
    checks++;
    if (rd_busy_o[1] !== 1'b0) begin
      failures++; $display("FAIL multi_busy got %b exp 0", rd_busy_o[1]);
    end
    checks++;
    if (wb_err_o !== 1'b0) begin
      failures++; $display("FAIL multi_err got %b exp 0", wb_err_o);
    end
  endtask

  task automatic test_underflow();
    rd_r_i[0 +: AW] = 4'd9;
    wb_i = 2'b01; wb_r_i[0 +: AW] = 4'd9; wb_data_i[0 +: W] = 32'h1234_5678;
    tick();
    idle();
    #1;
    checks++;
    if (wb_err_o !== 1'b1) begin
      failures++; $display("FAIL uflow_err got %b exp 1", wb_err_o);
    end
    checks++;
    if (rd_data_o[0 +: W] !== 32'h1234_5678 || rd_busy_o[0] !== 1'b0) begin
      failures++; $display("FAIL uflow_reg got %h/%b exp 12345678/0", rd_data_o[0 +: W], rd_busy_o[0]);
    end
    tick();
    tick();
    checks++;
    if (wb_err_o !== 1'b1) begin
      failures++; $display("FAIL uflow_hold got %b exp 1", wb_err_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (wb_err_o !== 1'b0) begin
      failures++; $display("FAIL uflow_rst got %b exp 0", wb_err_o);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      w_reserve_i = $urandom_range(0, 1);
      rsv_r_i = AW'($urandom_range(0, 3));
      for (int j = 0; j < NWB; j++) begin
        r = $urandom_range(0, 3);
        wb_r_i[j*AW +: AW] = AW'(r);
        wb_data_i[j*W +: W] = $urandom;
        wb_i[j] = ($urandom_range(0, 9) < 4) && (m_cnt[r] > 0 || $urandom_range(0, 19) == 0);
      end
      for (int k = 0; k < NRD; k++)
        rd_r_i[k*AW +: AW] = AW'($urandom_range(0, 4));
      #1;
      for (int k = 0; k < NRD; k++) begin
        r = int'(rd_r_i[k*AW +: AW]);
        checks++;
        if (rd_busy_o[k] !== exp_busy(r)) begin
          failures++; $display("FAIL rand_busy c=%0d k=%0d r=%0d got %b exp %b", c, k, r, rd_busy_o[k], exp_busy(r));
        end
        checks++;
        if (rd_data_o[k*W +: W] !== exp_data(r)) begin
          failures++; $display("FAIL rand_data c=%0d k=%0d r=%0d got %h exp %h", c, k, r, rd_data_o[k*W +: W], exp_data(r));
        end
      end
      checks++;
      if (rsv_stall_o !== exp_stall()) begin
        failures++; $display("FAIL rand_stall c=%0d got %b exp %b", c, rsv_stall_o, exp_stall());
      end
      checks++;
      if (wb_err_o !== m_err) begin
        failures++; $display("FAIL rand_err c=%0d got %b exp %b", c, wb_err_o, m_err);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_err = 1'b0;
    for (int r = 0; r < N; r++) begin
      m_data[r] = '0;
      m_cnt[r] = 0;
    end
    rst = 1'b1;
    w_reserve_i = 1'b0;
    rsv_r_i = '0;
    rd_r_i = '0;
    wb_i = '0;
    wb_r_i = '0;
    wb_data_i = '0;
    tick();
    test_reset();
    test_reserve_wb();
    test_stall();
    test_same_cycle();
    test_multi_wb();
    test_underflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/g_regfile_sb.md
G_REGFILE_SB -- requirements
Module: g_regfile_sb

Interface
REQ-001 SHALL have parameter W_OPR, default 32: operand/data width in bits.
REQ-002 SHALL have parameter REG_N, default 16: number of registers, a power of two, at least 2.
REQ-003 SHALL have parameter N_RD, default 2: number of read ports.
REQ-004 SHALL have parameter N_WB, default 2: number of write-back ports.
REQ-005 SHALL have parameter PEND_MAX, default 3: maximum outstanding reservations per register.
REQ-006 SHALL use a single clock `clk`; reset `rst` is synchronous and active-high.
REQ-007 SHALL have port `clk`, input, 1 bit: clock; all state updates on its rising edge.
REQ-008 SHALL have port `rst`, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port `w_reserve_i`, input, 1 bit: request a write reservation.
REQ-010 SHALL have port `rsv_r_i`, input, clog2(REG_N) bits: register to reserve.
REQ-011 SHALL have port `rsv_stall_o`, output, 1 bit: reservation refused this cycle.
REQ-012 SHALL have port `rd_r_i`, input, N_RD*clog2(REG_N) bits: read register numbers; port k occupies slice k.
REQ-013 SHALL have port `rd_data_o`, output, N_RD*W_OPR bits: read operands.
REQ-014 SHALL have port `rd_busy_o`, output, N_RD bits: the operand on port k is not yet valid.
REQ-015 SHALL have port `wb_i`, input, N_WB bits: write-back valid, one bit per port.
REQ-016 SHALL have port `wb_r_i`, input, N_WB*clog2(REG_N) bits: write-back register numbers.
REQ-017 SHALL have port `wb_data_i`, input, N_WB*W_OPR bits: write-back data.
REQ-018 SHALL have port `wb_err_o`, output, 1 bit: sticky flag for a write-back to an unreserved register.

Function
REQ-019 SHALL keep, per register, W_OPR data bits and a pending counter cnt (0..PEND_MAX).
REQ-020 SHALL make reads combinational: rd_data_o[k] = data[rd_r_i[k]], and rd_busy_o[k] = (cnt[rd_r_i[k]] != 0).
REQ-021 SHALL drive rsv_stall_o = w_reserve_i & (cnt[rsv_r_i] == PEND_MAX), combinationally; a stalled reservation does not change cnt.
REQ-022 SHALL, on an accepted reservation, increment cnt[rsv_r_i] by 1 at the next edge.
REQ-023 SHALL, for each valid write-back port j, decrement cnt[wb_r_i[j]] by 1 and write wb_data_i[j] to data at the next edge.
REQ-024 SHALL compute each register's next cnt as cnt + accepted reserve − number of write-back hits, applied in the same edge (reserve plus one write-back to the same register leaves cnt unchanged).
REQ-025 SHALL, when several write-back ports target one register in a cycle, store the data of the highest-index port.
REQ-026 SHALL, on underflow (hits exceed cnt + reserve), clamp cnt to 0, still write the data, and set wb_err_o from the next cycle until reset.
REQ-027 SHALL NOT let a reservation made in the current cycle affect rd_busy_o in that cycle.
REQ-028 SHALL allow read, reserve and write-back of the same register in the same cycle.

Reset
REQ-029 SHALL, with rst high at an edge, clear all data to 0, all cnt to 0 and wb_err_o to 0, and ignore w_reserve_i and wb_i in that cycle.
REQ-030 SHALL therefore, in the cycle after reset, read rd_data_o = 0, rd_busy_o = 0 and rsv_stall_o = 0 (when cnt is 0).

Configuration
REQ-031 SHALL support macro GREG_BYPASS_EN; when it is defined, rd_busy_o[k] = ((cnt − hits) != 0) for register rd_r_i[k], and rd_data_o[k] = highest-index matching wb_data_i when hits > 0.
REQ-032 SHALL, when GREG_BYPASS_EN is undefined, behave exactly as REQ-020: no forwarding, so a write-back becomes visible one cycle later.

Structure
REQ-033 SHALL put W_OPR and REG_N defaults, PEND_MAX, the cnt width (clog2(PEND_MAX+1)) and a clog2 function in the shared package greg_pkg.
REQ-034 SHALL implement one register as sub-module greg_entry (data, cnt, inc/dec inputs), replicated REG_N times via generate.

Verification
REQ-035 SHALL check: reset, then read r5 -> rd_data_o = 0, rd_busy_o = 0, wb_err_o = 0.
REQ-036 SHALL check: reserve r3, then write back r3 = 0xDEADBEEF two cycles later -> busy = 1 for 2 cycles, then busy = 0 and data = 0xDEADBEEF; with GREG_BYPASS_EN, busy = 0 and data forwarded in the write-back cycle.
REQ-037 SHALL check: reserve r7 four times in consecutive cycles with PEND_MAX = 3 -> rsv_stall_o = 1 on the 4th, cnt = 3; three write-backs -> busy clears after the third.
REQ-038 SHALL check: reserve r2 and write back r2 in the same cycle with cnt = 1 -> cnt stays 1, busy stays 1, data updated.
REQ-039 SHALL check: ports 0 and 1 both write back r4 with 0x11 and 0x22 while cnt = 2 -> data = 0x22, cnt = 0.
REQ-040 SHALL check: write back r9 with cnt = 0 -> wb_err_o = 1 next cycle and held; assert rst -> wb_err_o = 0.
